// File: rtl/imem_loader_if.sv
// imem_loader_if: start/byte-stream inputs, instruction-memory write port and status outputs
interface imem_loader_if #(parameter int ADDR_W = 6);
  logic              start;
  logic [6:0]        word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              irom_we;
  logic [ADDR_W-1:0] irom_addr;
  logic [31:0]       irom_din;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, irom_we, irom_addr, irom_din, cpu_rst, busy, done, err
  );
  modport slave (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, irom_we, irom_addr, irom_din, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into big-endian instruction words, writes them to IROM, verifies an XOR checksum
module imem_loader #(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 64
) (
  input logic           clk,
  input logic           rst,
  imem_loader_if.master bus
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] MAXW = CW'(MAX_WORDS);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        xor_q, xor_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     nw_q, nw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              acc;
  assign acc            = bus.byte_valid & ready_q;
  assign bus.byte_ready = ready_q;
  assign bus.irom_we    = we_q;
  assign bus.irom_addr  = addr_q;
  assign bus.irom_din   = din_q;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  // next-state and registered-output computation; byte_ready follows the state being entered
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    xor_d     = xor_q;
    cnt_d     = cnt_q;
    nw_d      = nw_q;
    addr_d    = addr_q;
    din_d     = din_q;
    we_d      = 1'b0;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d   = RECV;
        cnt_d     = (bus.word_count == 7'd0) ? MAXW : CW'(bus.word_count);
        idx_d     = 2'd0;
        word_d    = 24'd0;
        xor_d     = 8'd0;
        nw_d      = '0;
        addr_d    = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        busy_d    = 1'b1;
        cpu_rst_d = 1'b1;
      end
      RECV: if (acc) begin
        word_d = {word_q[15:0], bus.byte_data};
        xor_d  = xor_q ^ bus.byte_data;
        idx_d  = idx_q + 1'b1;
        if (idx_q == 2'd3) begin
          state_d = WRITE;
          we_d    = 1'b1;
          din_d   = {word_q, bus.byte_data};
        end
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        nw_d    = nw_q + 1'b1;
        state_d = (nw_q + 1'b1 == cnt_q) ? CHECK : RECV;
      end
      CHECK: if (acc) begin
        state_d   = DONE;
        err_d     = bus.byte_data != xor_q;
        cpu_rst_d = bus.byte_data != xor_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == RECV) || (state_d == CHECK);
  end
  // state and output registers, asynchronously cleared with the CPU held in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      word_q    <= 24'd0;
      xor_q     <= 8'd0;
      cnt_q     <= '0;
      nw_q      <= '0;
      addr_q    <= '0;
      din_q     <= 32'd0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      xor_q     <= xor_d;
      cnt_q     <= cnt_d;
      nw_q      <= nw_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against a queue-based write/checksum model
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  imem_loader_if #(.ADDR_W(6)) bus();
  imem_loader #(.ADDR_W(6), .MAX_WORDS(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {logic [5:0] a; logic [31:0] d;} wr_t;
  wr_t         exp_q[$];
  logic [31:0] wbuf [64];
  logic [7:0]  last_x;
  logic        tog = 1'b0;
  logic        prev_we = 1'b0;
  int          checks = 0;
  int          errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // every write strobe must match the next expected (addr, word) and be a lone cycle without byte_ready
  always @(negedge clk) begin
    if (bus.irom_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: got write addr %0h din %0h, expected no write", bus.irom_addr, bus.irom_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.irom_addr), 32'(e.a));
        chk("wr_din", bus.irom_din, e.d);
      end
      chk("we_single", 32'(prev_we), 32'd0);
      chk("rdy_in_write", 32'(bus.byte_ready), 32'd0);
    end
    prev_we = bus.irom_we;
  end
  task automatic do_start(input logic [6:0] wc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.word_count = wc;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.word_count = 7'($urandom);
  endtask
  task automatic send_byte(input logic [7:0] b, input int mode);
    for (int t = 0; t < 200; t++) begin
      logic v, r;
      @(negedge clk);
      r = bus.byte_ready;
      if (mode == 0) v = 1'b1;
      else if (mode == 1) begin tog = ~tog; v = tog; end
      else v = ($urandom_range(0, 2) != 0);
      bus.byte_valid = v;
      bus.byte_data = v ? b : 8'($urandom);
      @(posedge clk);
      if (v && r) return;
    end
    checks++;
    errors++;
    $display("FAIL byte_timeout: got no accept of %0h, expected accept within 200 cycles", b);
  endtask
  task automatic run_load(input logic [6:0] wc, input int mode, input logic [7:0] flip, input int glitch);
    int n;
    logic [7:0] x;
    n = (wc == 7'd0) ? 64 : int'(wc);
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{a: 6'(i), d: wbuf[i]});
      for (int b = 0; b < 4; b++) x ^= wbuf[i][31-8*b -: 8];
    end
    last_x = x;
    do_start(wc);
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    chk("start_done", 32'(bus.done), 32'd0);
    chk("start_err", 32'(bus.err), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i == glitch) begin
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.start = 1'b1;
        bus.word_count = 7'(n + 3);
        @(negedge clk);
        bus.start = 1'b0;
      end
      for (int b = 0; b < 4; b++) send_byte(wbuf[i][31-8*b -: 8], mode);
    end
    send_byte(x ^ flip, mode);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    for (int t = 0; t < 20 && !bus.done; t++) @(negedge clk);
    chk("end_done", 32'(bus.done), 32'd1);
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_err", 32'(bus.err), 32'(flip != 8'd0));
    chk("end_cpu_rst", 32'(bus.cpu_rst), 32'(flip != 8'd0));
    chk("end_addr", 32'(bus.irom_addr), 32'(6'(n)));
    chk("end_ready", 32'(bus.byte_ready), 32'd0);
    chk("end_pending", 32'(exp_q.size()), 32'd0);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(bus.irom_we), 32'd0);
    chk({tag, "_addr"}, 32'(bus.irom_addr), 32'd0);
    chk({tag, "_din"}, bus.irom_din, 32'd0);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_cpu_rst"}, 32'(bus.cpu_rst), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.word_count = 7'd0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'd0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset_vals("idle");
    wbuf[0] = 32'h20080005;
    run_load(7'd1, 0, 8'h00, -1);
    chk("r035_xor_model", 32'(last_x), 32'h2d);
    chk("r035_din", bus.irom_din, 32'h20080005);
    wbuf[0] = 32'h01020304;
    wbuf[1] = 32'h05060708;
    run_load(7'd2, 0, 8'h00, -1);
    chk("r036_xor_model", 32'(last_x), 32'h08);
    chk("r036_din", bus.irom_din, 32'h05060708);
    run_load(7'd2, 1, 8'h08, -1);
    run_load(7'd2, 1, 8'h00, -1);
    for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
    run_load(7'd0, 0, 8'h00, -1);
    run_load(7'd3, 2, 8'h00, 1);
    for (int k = 0; k < 6; k++) begin
      logic [7:0] f;
      for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
      f = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_load(7'($urandom_range(1, 20)), $urandom_range(0, 2), f, $urandom_range(0, 4));
    end
    for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
    exp_q.push_back('{a: 6'd0, d: wbuf[0]});
    exp_q.push_back('{a: 6'd1, d: wbuf[1]});
    do_start(7'd4);
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) send_byte(wbuf[i][31-8*b -: 8], 0);
    send_byte(wbuf[2][31:24], 0);
    send_byte(wbuf[2][23:16], 0);
    #2;
    rst = 1'b0;
    bus.byte_valid = 1'b0;
    #1;
    chk_reset_vals("r039_async");
    chk("r039_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk_reset_vals("r039_idle");
    for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
    run_load(7'd4, 2, 8'h00, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
